sync_debounce: RTL and testbench

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce.sv | 138 +++++++++++++
 tb/tb_sync_debounce.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a four-state stability FSM producing a debounced level.
// Optional fall pulse output is enabled by defining SYNC_DEBOUNCE_FALL_EN.
module sync_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic busy,
    output logic rise
`ifdef SYNC_DEBOUNCE_FALL_EN
    ,
    output logic fall
`endif
);

    localparam logic [1:0] LOW      = 2'd0;
    localparam logic [1:0] CHK_HIGH = 2'd1;
    localparam logic [1:0] HIGH     = 2'd2;
    localparam logic [1:0] CHK_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
`ifdef SYNC_DEBOUNCE_FALL_EN
    logic             fall_q, fall_d;
`endif

    // Only the second synchronizer stage is allowed to influence the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
`ifdef SYNC_DEBOUNCE_FALL_EN
        fall_d  = 1'b0;
`endif
        case (state_q)
            LOW: begin
                if (sync2_q) begin
                    state_d = CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            CHK_HIGH: begin
                if (!sync2_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = CHK_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            CHK_LOW: begin
                // A returning 1 is a glitch: abandon the fall and restart the count.
                if (sync2_q) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    q_d     = 1'b0;
`ifdef SYNC_DEBOUNCE_FALL_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
        end
    end

`ifdef SYNC_DEBOUNCE_FALL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;
`endif

    assign q    = q_q;
    assign rise = rise_q;
    assign busy = (state_q == CHK_HIGH) || (state_q == CHK_LOW);

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: a run-length model predicts each cycle's outputs
// for a STABLE_CYCLES=4 and a STABLE_CYCLES=2 instance sharing the same stimulus.
module tb_sync_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d   = 1'b0;
    logic q, busy, rise;
    logic q2, busy2, rise2;
`ifdef SYNC_DEBOUNCE_FALL_EN
    logic fall, fall2;
`endif

    int testsRun  = 0;
    int testsFail = 0;
    int riseCount = 0;
    int fallCount = 0;

    typedef struct {
        logic s1;
        logic s2;
        logic q;
        logic rise;
        logic fall;
        logic busy;
        int   run;
    } model_t;

    typedef struct {
        logic q;
        logic rise;
        logic fall;
        logic busy;
        logic q2;
        logic rise2;
        logic busy2;
    } exp_t;

    model_t m4, m2;
    exp_t   expQ[$];
    exp_t   cur;

    always #5 clk = ~clk;

    sync_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .q    (q),
        .busy (busy),
        .rise (rise)
`ifdef SYNC_DEBOUNCE_FALL_EN
        ,
        .fall (fall)
`endif
    );

    sync_debounce #(.STABLE_CYCLES(2), .CNT_W(8)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .q    (q2),
        .busy (busy2),
        .rise (rise2)
`ifdef SYNC_DEBOUNCE_FALL_EN
        ,
        .fall (fall2)
`endif
    );

    // The debounced level flips once the synchronized input has disagreed with it
    // for s consecutive edges; any agreeing sample resets that run.
    function automatic model_t stepModel(model_t m, logic dIn, logic rIn, int s);
        model_t n;
        n = m;
        if (rIn) begin
            n = '{s1: 1'b0, s2: 1'b0, q: 1'b0, rise: 1'b0, fall: 1'b0, busy: 1'b0, run: 0};
            return n;
        end
        n.rise = 1'b0;
        n.fall = 1'b0;
        n.s1   = dIn;
        n.s2   = m.s1;
        if (m.s2 != m.q) begin
            n.run = m.run + 1;
            if (n.run == s) begin
                n.q    = m.s2;
                n.rise = m.s2;
                n.fall = ~m.s2;
                n.run  = 0;
            end
        end else begin
            n.run = 0;
        end
        n.busy = (n.run != 0);
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic dVal, input logic rstVal);
        exp_t e;
        @(negedge clk);
        d   = dVal;
        rst = rstVal;
        m4  = stepModel(m4, dVal, rstVal, 4);
        m2  = stepModel(m2, dVal, rstVal, 2);
        e.q     = m4.q;
        e.rise  = m4.rise;
        e.fall  = m4.fall;
        e.busy  = m4.busy;
        e.q2    = m2.q;
        e.rise2 = m2.rise;
        e.busy2 = m2.busy;
        expQ.push_back(e);
    endtask

    task automatic holdLevel(input logic dVal, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(dVal, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            checkOutput("q",     {7'd0, q},     {7'd0, cur.q});
            checkOutput("rise",  {7'd0, rise},  {7'd0, cur.rise});
            checkOutput("busy",  {7'd0, busy},  {7'd0, cur.busy});
            checkOutput("q2",    {7'd0, q2},    {7'd0, cur.q2});
            checkOutput("rise2", {7'd0, rise2}, {7'd0, cur.rise2});
            checkOutput("busy2", {7'd0, busy2}, {7'd0, cur.busy2});
            if (rise) riseCount++;
`ifdef SYNC_DEBOUNCE_FALL_EN
            checkOutput("fall",  {7'd0, fall},  {7'd0, cur.fall});
            checkOutput("riseFallExcl", {7'd0, rise & fall}, 8'd0);
            if (fall) fallCount++;
`endif
        end
    end

    initial begin
        m4 = '{s1: 1'b0, s2: 1'b0, q: 1'b0, rise: 1'b0, fall: 1'b0, busy: 1'b0, run: 0};
        m2 = m4;

        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);

        // Glitch while low: two highs then back to low.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        holdLevel(1'b0, 6);

        holdLevel(1'b1, 8);
        holdLevel(1'b0, 8);

        // Reset lands while the slow instance sits in CHK_HIGH with cnt=2.
        holdLevel(1'b1, 4);
        applyStimulus(1'b1, 1'b1);
        holdLevel(1'b1, 8);
        holdLevel(1'b0, 8);

        for (int i = 0; i < 50; i++) applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0);
        holdLevel(1'b0, 4);

        @(posedge clk);
        #3;
        checkOutput("riseCount", 8'(riseCount), 8'd2);
`ifdef SYNC_DEBOUNCE_FALL_EN
        checkOutput("fallCount", 8'(fallCount), 8'd2);
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
